// File: rtl/wb_pkg.sv
// Shared definitions for the writeback-destination queue: register-file geometry,
// the queued entry layout and a one-hot helper for the pending-write mask.
package wb_pkg;

  localparam int REG_COUNT = 16;
  localparam int REG_IDX_W = 4;
  localparam int WB_DATA_W = 64;

  typedef struct packed {
    logic [REG_IDX_W-1:0] reg_idx;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [REG_COUNT-1:0] onehot16(input logic [REG_IDX_W-1:0] idx);
    logic [REG_COUNT-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/wb_dest_queue_if.sv
// Request/strobe bundle between the writeback producer, the queue and the
// register-write decoder.
interface wb_dest_queue_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
);

  logic                          in_valid;
  logic                          in_ready;
  logic [wb_pkg::REG_IDX_W-1:0]  in_reg;
  logic [DATA_WIDTH-1:0]         in_data;
  logic                          flush;
  logic                          rf_stall;
  logic                          dec_enable;
  logic [wb_pkg::REG_IDX_W-1:0]  dec_sel;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [wb_pkg::REG_COUNT-1:0]  busy_mask;
  logic [$clog2(DEPTH):0]        count;

  modport master (
    output in_valid, in_reg, in_data, flush, rf_stall,
    input  in_ready, dec_enable, dec_sel, wr_data, busy_mask, count
  );

  modport slave (
    input  in_valid, in_reg, in_data, flush, rf_stall,
    output in_ready, dec_enable, dec_sel, wr_data, busy_mask, count
  );

endinterface

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO; full/empty come from the occupancy count so pointer
// equality is never ambiguous. Exposes its storage and per-slot valid bits.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output entry_t           entries [DEPTH],
  output logic [DEPTH-1:0] valid_vec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + 1'b1;
      if (pop_ok)  head_d = head_q + 1'b1;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: slots are only observed through valid_vec / count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= push_data;
  end

  assign head    = mem_q[head_q];
  assign entries = mem_q;
  assign count   = count_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [PTR_W-1:0] offs;
    assign offs          = PTR_W'(gi) - head_q;
    assign valid_vec[gi] = (CNT_W'(offs) < count_q);
  end

endmodule

// File: rtl/wb_dest_queue.sv
// Writeback-destination queue: buffers register writes and drains one registered
// strobe per cycle into the 4-to-16 write decoder, publishing a pending-write mask.
module wb_dest_queue
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input logic            clk,
  input logic            rst,
  wb_dest_queue_if.slave bus
);

  typedef struct packed {
    logic [REG_IDX_W-1:0]  reg_idx;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                 push_entry;
  entry_t                 head;
  entry_t                 entries [DEPTH];
  logic [DEPTH-1:0]       valid_vec;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;

  logic                   dec_enable_q, dec_enable_d;
  logic [REG_IDX_W-1:0]   dec_sel_q, dec_sel_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [REG_COUNT-1:0]   entry_mask [DEPTH];
  logic [REG_COUNT-1:0]   busy_mask;

  // No pop credit on a full queue: readiness depends on occupancy alone.
  assign bus.in_ready = !rst && !bus.flush && !full;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = !rst && !bus.flush && !bus.rf_stall && !empty;
  assign push_entry   = '{reg_idx: bus.in_reg, data: bus.in_data};

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.flush),
    .head      (head),
    .entries   (entries),
    .valid_vec (valid_vec),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    dec_enable_d = pop;
    dec_sel_d    = dec_sel_q;
    wr_data_d    = wr_data_q;
    if (pop) begin
      dec_sel_d = head.reg_idx;
      wr_data_d = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_enable_q <= 1'b0;
      dec_sel_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      dec_enable_q <= dec_enable_d;
      dec_sel_q    <= dec_sel_d;
      wr_data_q    <= wr_data_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
    assign entry_mask[gi] = valid_vec[gi] ? onehot16(entries[gi].reg_idx) : '0;
  end

  // The in-flight strobe still counts as pending until it has been written.
  always_comb begin
    busy_mask = dec_enable_q ? onehot16(dec_sel_q) : '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_mask = busy_mask | entry_mask[i];
    end
  end

  assign bus.dec_enable = dec_enable_q;
  assign bus.dec_sel    = dec_sel_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy_mask  = busy_mask;
  assign bus.count      = fifo_count;

endmodule

// File: tb/tb_wb_dest_queue.sv
// Bench for wb_dest_queue: directed vector table, hand sequences and random
// traffic, all compared against a queue-based reference model.
module tb_wb_dest_queue;

  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  wb_dest_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  wb_dest_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  r;
    logic [63:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_en;
  logic [3:0]  m_sel;
  logic [63:0] m_data;

  logic        s_ready;
  logic        s_en;
  logic [3:0]  s_sel;
  logic [63:0] s_data;
  logic [15:0] s_busy;
  int          s_cnt;

  typedef struct {
    logic        v;
    logic [3:0]  r;
    logic [63:0] d;
    logic        st;
    logic        ex_ready;
    logic        ex_en;
    logic [3:0]  ex_sel;
    logic [63:0] ex_data;
    int          ex_cnt;
    logic [15:0] ex_busy;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model_busy();
    logic [15:0] b;
    b = m_en ? (16'd1 << m_sel) : 16'd0;
    foreach (mq[i]) b = b | (16'd1 << mq[i].r);
    return b;
  endfunction

  task automatic cycle(input logic v, input logic [3:0] r, input logic [63:0] d,
                       input logic fl, input logic st, input logic rs);
    logic exp_ready;
    logic accept;
    ent_t e;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_reg   = r;
    bus.in_data  = d;
    bus.flush    = fl;
    bus.rf_stall = st;
    rst          = rs;
    #1;
    s_ready   = bus.in_ready;
    exp_ready = !rs && !fl && (mq.size() < DEPTH);
    chk("in_ready", 64'(s_ready), 64'(exp_ready));
    @(posedge clk);
    if (rs) begin
      mq.delete();
      m_en   = 1'b0;
      m_sel  = 4'd0;
      m_data = 64'd0;
    end else if (fl) begin
      mq.delete();
      m_en = 1'b0;
    end else begin
      accept = v && (mq.size() < DEPTH);
      if (!st && mq.size() > 0) begin
        e      = mq.pop_front();
        m_en   = 1'b1;
        m_sel  = e.r;
        m_data = e.d;
      end else begin
        m_en = 1'b0;
      end
      if (accept) mq.push_back('{r: r, d: d});
    end
    #1;
    s_en   = bus.dec_enable;
    s_sel  = bus.dec_sel;
    s_data = bus.wr_data;
    s_busy = bus.busy_mask;
    s_cnt  = int'(bus.count);
    chk("dec_enable", 64'(s_en), 64'(m_en));
    chk("count", 64'(s_cnt), 64'(mq.size()));
    chk("busy_mask", 64'(s_busy), 64'(model_busy()));
    if (m_en || rs) begin
      chk("dec_sel", 64'(s_sel), 64'(m_sel));
      chk("wr_data", s_data, m_data);
    end
    if (s_en) $display("[TB] write reg=%0d data=%0h count=%0d", s_sel, s_data, s_cnt);
  endtask

  function automatic vec_t mk(input logic v, input logic [3:0] r, input logic [63:0] d,
                              input logic st, input logic rdy, input logic en,
                              input logic [3:0] sel, input logic [63:0] dat,
                              input int cnt, input logic [15:0] busy);
    vec_t t;
    t = '{v: v, r: r, d: d, st: st, ex_ready: rdy, ex_en: en, ex_sel: sel,
          ex_data: dat, ex_cnt: cnt, ex_busy: busy};
    return t;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    mq.delete();
    m_en   = 1'b0;
    m_sel  = 4'd0;
    m_data = 64'd0;
    bus.in_valid = 1'b0;
    bus.in_reg   = 4'd0;
    bus.in_data  = 64'd0;
    bus.flush    = 1'b0;
    bus.rf_stall = 1'b0;
    rst          = 1'b1;

    // Single write latency, then a full stalled queue draining in order.
    tbl[0]  = mk(1, 4'd5, 64'hAB, 0, 1, 0, 4'd0, 64'h0,  1, 16'h0020);
    tbl[1]  = mk(0, 4'd0, 64'h0,  0, 1, 1, 4'd5, 64'hAB, 0, 16'h0020);
    tbl[2]  = mk(0, 4'd0, 64'h0,  0, 1, 0, 4'd0, 64'h0,  0, 16'h0000);
    tbl[3]  = mk(1, 4'd1, 64'h11, 1, 1, 0, 4'd0, 64'h0,  1, 16'h0002);
    tbl[4]  = mk(1, 4'd2, 64'h22, 1, 1, 0, 4'd0, 64'h0,  2, 16'h0006);
    tbl[5]  = mk(1, 4'd3, 64'h33, 1, 1, 0, 4'd0, 64'h0,  3, 16'h000E);
    tbl[6]  = mk(1, 4'd4, 64'h44, 1, 1, 0, 4'd0, 64'h0,  4, 16'h001E);
    tbl[7]  = mk(1, 4'd6, 64'h66, 1, 0, 0, 4'd0, 64'h0,  4, 16'h001E);
    tbl[8]  = mk(0, 4'd0, 64'h0,  0, 0, 1, 4'd1, 64'h11, 3, 16'h001E);
    tbl[9]  = mk(0, 4'd0, 64'h0,  0, 1, 1, 4'd2, 64'h22, 2, 16'h001C);
    tbl[10] = mk(0, 4'd0, 64'h0,  0, 1, 1, 4'd3, 64'h33, 1, 16'h0018);
    tbl[11] = mk(0, 4'd0, 64'h0,  0, 1, 1, 4'd4, 64'h44, 0, 16'h0010);
    tbl[12] = mk(0, 4'd0, 64'h0,  0, 1, 0, 4'd0, 64'h0,  0, 16'h0000);

    cycle(1, 4'd3, 64'h5, 0, 0, 1);
    cycle(0, 4'd0, 64'h0, 0, 0, 1);

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].v, tbl[i].r, tbl[i].d, 1'b0, tbl[i].st, 1'b0);
      chk($sformatf("vec%0d_ready", i), 64'(s_ready), 64'(tbl[i].ex_ready));
      chk($sformatf("vec%0d_en", i), 64'(s_en), 64'(tbl[i].ex_en));
      chk($sformatf("vec%0d_count", i), 64'(s_cnt), 64'(tbl[i].ex_cnt));
      chk($sformatf("vec%0d_busy", i), 64'(s_busy), 64'(tbl[i].ex_busy));
      if (tbl[i].ex_en) begin
        chk($sformatf("vec%0d_sel", i), 64'(s_sel), 64'(tbl[i].ex_sel));
        chk($sformatf("vec%0d_data", i), s_data, tbl[i].ex_data);
      end
    end

    // Streaming across pointer wrap: occupancy never builds up.
    for (int i = 0; i < 12; i++) begin
      cycle(1, 4'(i), 64'(32'hC000 + i), 0, 0, 0);
      chk("stream_count_le1", 64'(s_cnt <= 1), 64'd1);
    end
    cycle(0, 4'd0, 64'h0, 0, 0, 0);
    cycle(0, 4'd0, 64'h0, 0, 0, 0);

    // Repeated destination: bit 7 stays pending until the second reg-7 write.
    cycle(1, 4'd7, 64'h1, 0, 0, 0);
    cycle(1, 4'd7, 64'h2, 0, 0, 0);
    chk("same_reg_first", 64'({s_sel, s_data[7:0]}), 64'({4'd7, 8'h01}));
    cycle(1, 4'd9, 64'h99, 0, 0, 0);
    chk("same_reg_second", 64'({s_sel, s_data[7:0]}), 64'({4'd7, 8'h02}));
    chk("same_reg_bit7", 64'(s_busy[7]), 64'd1);
    cycle(0, 4'd0, 64'h0, 0, 0, 0);
    chk("same_reg_third", 64'(s_sel), 64'd9);
    chk("same_reg_bit7_clear", 64'(s_busy[7]), 64'd0);
    cycle(0, 4'd0, 64'h0, 0, 0, 0);

    // Flush with three queued entries and a competing push of reg 12.
    cycle(1, 4'd1, 64'h10, 0, 1, 0);
    cycle(1, 4'd2, 64'h20, 0, 1, 0);
    cycle(1, 4'd3, 64'h30, 0, 1, 0);
    cycle(1, 4'd12, 64'hCC, 1, 0, 0);
    chk("flush_count", 64'(s_cnt), 64'd0);
    chk("flush_busy", 64'(s_busy), 64'd0);
    for (int i = 0; i < 3; i++) cycle(0, 4'd0, 64'h0, 0, 0, 0);

    // Reset in the middle of a drain.
    cycle(1, 4'd4, 64'h40, 0, 1, 0);
    cycle(1, 4'd5, 64'h50, 0, 1, 0);
    cycle(1, 4'd6, 64'h60, 0, 0, 0);
    chk("pre_rst_strobe", 64'(s_en), 64'd1);
    cycle(1, 4'd8, 64'h80, 0, 0, 1);
    chk("rst_ready_low", 64'(s_ready), 64'd0);
    chk("rst_outputs", 64'({s_en, s_sel, s_busy}), 64'd0);
    for (int i = 0; i < 3; i++) cycle(0, 4'd0, 64'h0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 70), 4'($urandom), {$urandom, $urandom},
            1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 99) < 35),
            1'($urandom_range(0, 199) < 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_dest_queue.md
Name: wb_dest_queue

Overview:
- Writeback-destination queue that sits directly upstream of the 4-to-16 enabled register-write decoder.
- Accepts writeback requests (destination register index plus data) over a valid/ready handshake and buffers them in a small FIFO.
- Drains at most one request per cycle as a registered one-cycle write strobe: enable, 4-bit select and data, which drive the decoder and the register-file data bus.
- Publishes a 16-bit pending-write mask so issue logic can detect hazards against queued writes.

Parameters:
- DATA_WIDTH, 64, width of the writeback data word.
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a writeback request is present.
- in_ready  output  1  the queue can accept a request this cycle.
- in_reg  input  4  destination register index, 0..15.
- in_data  input  DATA_WIDTH  writeback data.
- flush  input  1  discard all queued and in-flight writes.
- rf_stall  input  1  the register file cannot take a write this cycle.
- dec_enable  output  1  one-cycle write strobe; feeds the decoder Enable input.
- dec_sel  output  4  register index; bit0..bit3 feed decoder Input_1..Input_4.
- wr_data  output  DATA_WIDTH  data that accompanies dec_enable.
- busy_mask  output  16  bit r is high while any queued or in-flight write targets register r.
- count  output  clog2(DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset (rst high at an edge):
  - count=0; FIFO pointers=0.
  - dec_enable=0, dec_sel=0, wr_data=0, busy_mask=0.
  - in_ready is held low combinationally while rst is high.
- in_ready = !rst && !flush && (count < DEPTH).
  - No same-cycle pop credit: a full queue deasserts in_ready even if a pop occurs that cycle.
- Push: in_valid && in_ready at an edge writes {in_reg, in_data} at the tail and advances the tail pointer.
- Pop: at each edge where !rst && !flush && !rf_stall && count>0:
  - the head entry loads into the output registers;
  - dec_enable=1 for that next cycle only;
  - the head pointer advances.
- Otherwise at each edge: dec_enable loads 0, while dec_sel and wr_data hold their values. dec_sel and wr_data are don't-care while dec_enable=0.
- Latency:
  - A request accepted at edge E into an empty queue drives dec_enable high from E+1 to E+2; there is no combinational bypass.
  - Sustained throughput is 1 write per cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Ordering:
  - Strict FIFO order.
  - Multiple entries targeting the same register are allowed and are issued in arrival order.
- Pointer wrap: pointers wrap modulo DEPTH. Full and empty are determined from count, never from pointer equality alone.
- rf_stall: the head entry is held, with no pop and no loss. The queue still accepts pushes while count < DEPTH.
- flush (at an edge):
  - count=0, pointers=0, dec_enable loads 0.
  - Any push presented in the same cycle is not accepted (in_ready is low).
  - flush has priority over rf_stall and over pop.
- busy_mask is combinational from registered state only: the OR over valid FIFO entries of onehot(reg), ORed with onehot(dec_sel) when dec_enable=1. It has no path from the in_* ports.
- Width rules: count never exceeds DEPTH; in_reg is used as the full 4 bits, with no reserved index.

Decomposition:
- Shared package wb_pkg:
  - REG_COUNT=16 and REG_IDX_W=4;
  - the typedef wb_entry_t {reg_idx [3:0], data [DATA_WIDTH-1:0]};
  - a onehot16(idx) function.
- One natural sub-module: wb_fifo, a generic synchronous FIFO of wb_entry_t with push, pop, flush, count and full/empty outputs.
- The output register stage and the busy_mask logic live in the top module. busy_mask needs read access to the FIFO valid-entry vector, which wb_fifo exports.

Test Plan:
- Reset, then push reg=5 with data 0xAB at edge E into an empty queue -> dec_enable=1 only during E+1..E+2 with dec_sel=5 and wr_data=0xAB; busy_mask=0x0020 until dec_enable drops, then 0x0000.
- Push regs 1,2,3,4 back-to-back with rf_stall=1 -> count=4, in_ready=0, busy_mask=0x001E. Release rf_stall -> four consecutive strobes with dec_sel 1,2,3,4 in order; count returns to 0.
- Continuous push and pop with in_valid held high for 12 cycles of incrementing regs (0..11) -> one strobe per cycle, no drops, correct order across pointer wrap; count stays ≤1.
- Two pushes to reg 7 (data 0x1, then 0x2) plus a push to reg 9 -> strobes 7/0x1, 7/0x2, 9 in order; busy_mask bit 7 stays high until the second reg-7 strobe completes.
- Queue holding 3 entries, then flush asserted together with in_valid (reg 12) -> next cycle count=0, dec_enable=0, busy_mask=0; reg 12 is never issued.
- rst asserted mid-drain with dec_enable=1 -> at the next edge all outputs are 0, in_ready is low during rst, and the queue is empty afterwards.
